// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        COMMIT,
        DRAIN
    } state_t;

    localparam logic SPI_CMD_WRITE = 1'b1;
    localparam logic SPI_CMD_READ  = 1'b0;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pad-side bundle: controller drives nCS/SCLK/COPI, peripheral drives CIPO/cipo_oe and exposes its FSM state.
interface spi_regfile_peripheral_if;
    import spi_pkg::*;

    logic   nCS;
    logic   SCLK;
    logic   COPI;
    logic   CIPO;
    logic   cipo_oe;
    state_t dbg_state;

    modport master (output nCS, SCLK, COPI, input CIPO, cipo_oe, dbg_state);
    modport slave  (input nCS, SCLK, COPI, output CIPO, cipo_oe, dbg_state);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with a history flop; reports the synchronized level and its edges.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral owning a bank of configuration registers, with write and read frames.
module spi_regfile_peripheral
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_regfile_peripheral_if.slave    spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_valid,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int HDR_LEN   = 1 + ADDR_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic ncs_level, ncs_rise, ncs_fall;
    logic copi_level, copi_rise_unused, copi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .d(spi.SCLK),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
        .clk(clk), .rst(rst), .d(spi.nCS),
        .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi_sync (
        .clk(clk), .rst(rst), .d(spi.COPI),
        .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [FRAME_LEN-2:0]       shin_q, shin_d;
    logic [FRAME_LEN-1:0]       shin_next;
    logic [DATA_W-1:0]          shout_q, shout_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic                       wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic                       frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]          hdr_addr, f_addr;
    logic                       hdr_rw, f_rw;
    logic [DATA_W-1:0]          f_data;

    // wr_valid is a single-cycle strobe with no back-pressure; wr_addr and regs_out
    // already hold the committed values in the cycle wr_valid is high.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shin_d      = shin_q;
        shout_d     = shout_q;
        regs_d      = regs_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        shin_next   = {shin_q, copi_level};
        cnt_inc     = cnt_q + CNT_W'(1);
        hdr_addr    = shin_next[ADDR_W-1:0];
        hdr_rw      = shin_next[ADDR_W];
        f_rw        = shin_next[FRAME_LEN-1];
        f_addr      = shin_next[DATA_W +: ADDR_W];
        f_data      = shin_next[DATA_W-1:0];

        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d = ADDR;
                    cnt_d   = '0;
                    shin_d  = '0;
                    shout_d = '0;
                end
            end
            ADDR: begin
                if (ncs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    shin_d = shin_next[FRAME_LEN-2:0];
                    cnt_d  = cnt_inc;
                    if (cnt_inc == CNT_W'(HDR_LEN)) begin
                        state_d = DATA;
                        shout_d = '0;
                        if (hdr_rw == SPI_CMD_READ) begin
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (hdr_addr == ADDR_W'(k)) shout_d = regs_q[k*DATA_W +: DATA_W];
                            end
                        end
                    end
                end
            end
            DATA: begin
                if (ncs_rise) begin
                    state_d     = IDLE;
                    shout_d     = '0;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    shin_d = shin_next[FRAME_LEN-2:0];
                    cnt_d  = cnt_inc;
                    if (cnt_inc == CNT_W'(FRAME_LEN)) begin
                        state_d = COMMIT;
                        shout_d = '0;
                        if (f_rw == SPI_CMD_WRITE) begin
                            if (int'(f_addr) < NUM_REGS) begin
                                for (int k = 0; k < NUM_REGS; k++) begin
                                    if (f_addr == ADDR_W'(k)) regs_d[k*DATA_W +: DATA_W] = f_data;
                                end
                                wr_valid_d = 1'b1;
                                wr_addr_d  = f_addr;
                            end else begin
                                frame_err_d = 1'b1;
                            end
                        end
                    end
                end else if (sclk_fall && cnt_q != CNT_W'(HDR_LEN)) begin
                    // The fall right after the last address bit only presents the MSB loaded at that rise.
                    shout_d = shout_q << 1;
                end
            end
            COMMIT:  state_d = ncs_rise ? IDLE : DRAIN;
            DRAIN:   if (ncs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shin_q      <= '0;
            shout_q     <= '0;
            regs_q      <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shin_q      <= shin_d;
            shout_q     <= shout_d;
            regs_q      <= regs_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign regs_out      = regs_q;
    assign wr_valid      = wr_valid_q;
    assign wr_addr       = wr_addr_q;
    assign frame_err     = frame_err_q;
    assign spi.CIPO      = shout_q[DATA_W-1];
    assign spi.cipo_oe   = ~ncs_level;
    assign spi.dbg_state = state_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: default build (5x8-bit) and a 16x16-bit build side by side.
module tb_spi_regfile_peripheral;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic ncs_p [2];
    logic sclk_p[2];
    logic copi_p[2];

    spi_regfile_peripheral_if bus0();
    spi_regfile_peripheral_if bus1();
    assign bus0.nCS  = ncs_p[0];
    assign bus0.SCLK = sclk_p[0];
    assign bus0.COPI = copi_p[0];
    assign bus1.nCS  = ncs_p[1];
    assign bus1.SCLK = sclk_p[1];
    assign bus1.COPI = copi_p[1];

    logic [39:0]  regs0;
    logic [255:0] regs1;
    logic         wr_valid0, wr_valid1, frame_err0, frame_err1;
    logic [6:0]   wr_addr0, wr_addr1;

    spi_regfile_peripheral #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .spi(bus0), .regs_out(regs0),
        .wr_valid(wr_valid0), .wr_addr(wr_addr0), .frame_err(frame_err0)
    );
    spi_regfile_peripheral #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(7), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .spi(bus1), .regs_out(regs1),
        .wr_valid(wr_valid1), .wr_addr(wr_addr1), .frame_err(frame_err1)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_r [2][16];

    int wr_cnt0 = 0, wr_cnt1 = 0, err_cnt0 = 0, err_cnt1 = 0;
    logic [6:0]  last_addr0 = '0, last_addr1 = '0;
    logic [15:0] last_data0 = '0, last_data1 = '0;

    function automatic logic [15:0] get_reg(input int inst, input int k);
        if (inst == 0) return (k < 5) ? {8'h00, regs0[k*8 +: 8]} : 16'h0000;
        return regs1[k*16 +: 16];
    endfunction

    always @(negedge clk) begin
        if (wr_valid0) begin
            wr_cnt0++;
            last_addr0 = wr_addr0;
            last_data0 = get_reg(0, int'(wr_addr0));
        end
        if (frame_err0) err_cnt0++;
    end

    always @(negedge clk) begin
        if (wr_valid1) begin
            wr_cnt1++;
            last_addr1 = wr_addr1;
            last_data1 = get_reg(1, int'(wr_addr1));
        end
        if (frame_err1) err_cnt1++;
    end

    function automatic int dwidth(input int inst);
        return (inst == 0) ? 8 : 16;
    endfunction

    function automatic logic [15:0] dval(input int inst, input logic [7:0] b);
        return (inst == 0) ? {8'h00, b} : {b, ~b};
    endfunction

    function automatic int wr_count(input int inst);
        return (inst == 0) ? wr_cnt0 : wr_cnt1;
    endfunction

    function automatic int err_count(input int inst);
        return (inst == 0) ? err_cnt0 : err_cnt1;
    endfunction

    function automatic logic [6:0] last_addr(input int inst);
        return (inst == 0) ? last_addr0 : last_addr1;
    endfunction

    function automatic logic [15:0] last_data(input int inst);
        return (inst == 0) ? last_data0 : last_data1;
    endfunction

    function automatic int reg_mism(input int inst);
        int n = 0;
        int nr = (inst == 0) ? 5 : 16;
        for (int k = 0; k < nr; k++) if (get_reg(inst, k) !== exp_r[inst][k]) n++;
        return n;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode-0 controller: COPI changes while SCLK is low, CIPO is sampled just before each rise.
    task automatic spi_xfer(input int inst, input logic rw, input logic [6:0] addr,
                            input logic [15:0] data, input int stop_at, input bit raise,
                            input int extra, output logic [31:0] cap);
        int dw = dwidth(inst);
        int nb = 8 + dw;
        logic [31:0] fr;
        logic b;
        fr = (32'(rw) << (7 + dw)) | (32'(addr) << dw) | 32'(data);
        cap = '0;
        ncs_p[inst] = 1'b0;
        clks(8);
        for (int i = 0; i < nb + extra; i++) begin
            if (stop_at >= 0 && i == stop_at) break;
            if (i < nb) b = fr[nb-1-i];
            else        b = 1'($urandom_range(0, 1));
            copi_p[inst] = b;
            clks(8);
            cap = {cap[30:0], (inst == 0) ? bus0.CIPO : bus1.CIPO};
            sclk_p[inst] = 1'b1;
            clks(8);
            sclk_p[inst] = 1'b0;
        end
        if (raise) begin
            clks(8);
            ncs_p[inst] = 1'b1;
            clks(8);
        end
    endtask

    task automatic test_reset;
        checks++; if (regs0 !== '0) begin errors++; $display("FAIL reset_regs0: got %h want 0", regs0); end
        checks++; if (regs1 !== '0) begin errors++; $display("FAIL reset_regs1: got %h want 0", regs1); end
        checks++; if ({bus0.CIPO, bus1.CIPO} !== 2'b00) begin errors++; $display("FAIL reset_cipo: got %b want 00", {bus0.CIPO, bus1.CIPO}); end
        checks++; if ({bus0.cipo_oe, bus1.cipo_oe} !== 2'b00) begin errors++; $display("FAIL reset_cipo_oe: got %b want 00", {bus0.cipo_oe, bus1.cipo_oe}); end
        checks++; if ({wr_valid0, wr_valid1, frame_err0, frame_err1} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {wr_valid0, wr_valid1, frame_err0, frame_err1}); end
        checks++; if ({wr_addr0, wr_addr1} !== 14'd0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", {wr_addr0, wr_addr1}); end
        checks++; if (bus0.dbg_state !== IDLE || bus1.dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d/%0d want IDLE", bus0.dbg_state, bus1.dbg_state); end
    endtask

    task automatic test_write(input int inst);
        logic [31:0] cap;
        logic [15:0] d = dval(inst, 8'hA5);
        int w0 = wr_count(inst);
        int e0 = err_count(inst);
        spi_xfer(inst, 1'b1, 7'h00, d, -1, 1'b1, 0, cap);
        exp_r[inst][0] = d;
        @(negedge clk);
        checks++; if (wr_count(inst) - w0 !== 1) begin errors++; $display("FAIL write_wr_pulses[%0d]: got %0d want 1", inst, wr_count(inst) - w0); end
        checks++; if (last_addr(inst) !== 7'h00) begin errors++; $display("FAIL write_wr_addr[%0d]: got %h want 00", inst, last_addr(inst)); end
        checks++; if (last_data(inst) !== d) begin errors++; $display("FAIL write_data_at_strobe[%0d]: got %h want %h", inst, last_data(inst), d); end
        checks++; if (err_count(inst) !== e0) begin errors++; $display("FAIL write_no_err[%0d]: got %0d want %0d", inst, err_count(inst), e0); end
        checks++; if (cap !== 32'h0) begin errors++; $display("FAIL write_cipo_idle[%0d]: got %h want 0", inst, cap); end
        checks++; if (reg_mism(inst) !== 0) begin errors++; $display("FAIL write_regs[%0d]: got %0d mismatching regs want 0", inst, reg_mism(inst)); end
    endtask

    task automatic test_read_back(input int inst);
        logic [31:0] cap;
        logic [15:0] d = dval(inst, 8'hC3);
        int w0;
        spi_xfer(inst, 1'b1, 7'h04, d, -1, 1'b1, 0, cap);
        exp_r[inst][4] = d;
        w0 = wr_count(inst);
        spi_xfer(inst, 1'b0, 7'h04, 16'h0000, -1, 1'b1, 0, cap);
        @(negedge clk);
        checks++; if (cap !== 32'(d)) begin errors++; $display("FAIL read_cipo[%0d]: got %h want %h", inst, cap, 32'(d)); end
        checks++; if (wr_count(inst) !== w0) begin errors++; $display("FAIL read_no_wr[%0d]: got %0d want %0d", inst, wr_count(inst), w0); end
        checks++; if (reg_mism(inst) !== 0) begin errors++; $display("FAIL read_regs[%0d]: got %0d mismatching regs want 0", inst, reg_mism(inst)); end
    endtask

    task automatic test_out_of_range(input int inst);
        logic [31:0] cap;
        int w0 = wr_count(inst);
        int e0 = err_count(inst);
        spi_xfer(inst, 1'b1, 7'h7F, dval(inst, 8'hFF), -1, 1'b1, 0, cap);
        @(negedge clk);
        checks++; if (err_count(inst) - e0 !== 1) begin errors++; $display("FAIL oor_err_pulses[%0d]: got %0d want 1", inst, err_count(inst) - e0); end
        checks++; if (wr_count(inst) !== w0) begin errors++; $display("FAIL oor_no_wr[%0d]: got %0d want %0d", inst, wr_count(inst), w0); end
        checks++; if (reg_mism(inst) !== 0) begin errors++; $display("FAIL oor_regs[%0d]: got %0d mismatching regs want 0", inst, reg_mism(inst)); end
        spi_xfer(inst, 1'b0, 7'h7F, 16'h0000, -1, 1'b1, 0, cap);
        checks++; if (cap !== 32'h0) begin errors++; $display("FAIL oor_read[%0d]: got %h want 0", inst, cap); end
    endtask

    task automatic test_abort(input int inst);
        logic [31:0] cap;
        int w0 = wr_count(inst);
        int e0 = err_count(inst);
        spi_xfer(inst, 1'b1, 7'h01, dval(inst, 8'h22), 10, 1'b1, 0, cap);
        @(negedge clk);
        checks++; if (err_count(inst) - e0 !== 1) begin errors++; $display("FAIL abort_err_pulses[%0d]: got %0d want 1", inst, err_count(inst) - e0); end
        checks++; if (wr_count(inst) !== w0) begin errors++; $display("FAIL abort_no_wr[%0d]: got %0d want %0d", inst, wr_count(inst), w0); end
        checks++; if (reg_mism(inst) !== 0) begin errors++; $display("FAIL abort_regs[%0d]: got %0d mismatching regs want 0", inst, reg_mism(inst)); end
        spi_xfer(inst, 1'b1, 7'h01, dval(inst, 8'h33), -1, 1'b1, 0, cap);
        exp_r[inst][1] = dval(inst, 8'h33);
        @(negedge clk);
        checks++; if (wr_count(inst) - w0 !== 1 || last_addr(inst) !== 7'h01) begin errors++; $display("FAIL abort_recover_wr[%0d]: got %0d pulses addr %h want 1 addr 01", inst, wr_count(inst) - w0, last_addr(inst)); end
        checks++; if (reg_mism(inst) !== 0) begin errors++; $display("FAIL abort_recover_regs[%0d]: got %0d mismatching regs want 0", inst, reg_mism(inst)); end
    endtask

    task automatic test_drain(input int inst);
        logic [31:0] cap;
        int w0 = wr_count(inst);
        int e0 = err_count(inst);
        spi_xfer(inst, 1'b1, 7'h02, dval(inst, 8'h55), -1, 1'b1, 4, cap);
        exp_r[inst][2] = dval(inst, 8'h55);
        @(negedge clk);
        checks++; if (wr_count(inst) - w0 !== 1) begin errors++; $display("FAIL drain_wr_pulses[%0d]: got %0d want 1", inst, wr_count(inst) - w0); end
        checks++; if (err_count(inst) !== e0) begin errors++; $display("FAIL drain_no_err[%0d]: got %0d want %0d", inst, err_count(inst), e0); end
        checks++; if (last_data(inst) !== dval(inst, 8'h55)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", inst, last_data(inst), dval(inst, 8'h55)); end
        checks++; if (cap !== 32'h0) begin errors++; $display("FAIL drain_cipo[%0d]: got %h want 0", inst, cap); end
        checks++; if (reg_mism(inst) !== 0) begin errors++; $display("FAIL drain_regs[%0d]: got %0d mismatching regs want 0", inst, reg_mism(inst)); end
    endtask

    task automatic test_reset_mid(input int inst);
        logic [31:0] cap;
        logic oe;
        int w0;
        spi_xfer(inst, 1'b1, 7'h03, dval(inst, 8'h99), 12, 1'b0, 0, cap);
        oe = (inst == 0) ? bus0.cipo_oe : bus1.cipo_oe;
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL midrst_oe_in_frame[%0d]: got %b want 1", inst, oe); end
        rst = 1'b1;
        clks(2);
        checks++; if (regs0 !== '0 || regs1 !== '0) begin errors++; $display("FAIL midrst_regs[%0d]: got %h / %h want 0", inst, regs0, regs1); end
        checks++; if ({bus0.CIPO, bus1.CIPO, bus0.cipo_oe, bus1.cipo_oe} !== 4'b0000) begin errors++; $display("FAIL midrst_pins[%0d]: got %b want 0000", inst, {bus0.CIPO, bus1.CIPO, bus0.cipo_oe, bus1.cipo_oe}); end
        ncs_p[inst]  = 1'b1;
        sclk_p[inst] = 1'b0;
        clks(4);
        rst = 1'b0;
        clks(6);
        for (int i = 0; i < 2; i++) for (int k = 0; k < 16; k++) exp_r[i][k] = '0;
        w0 = wr_count(inst);
        spi_xfer(inst, 1'b1, 7'h03, dval(inst, 8'h99), -1, 1'b1, 0, cap);
        exp_r[inst][3] = dval(inst, 8'h99);
        @(negedge clk);
        checks++; if (wr_count(inst) - w0 !== 1) begin errors++; $display("FAIL midrst_wr_pulses[%0d]: got %0d want 1", inst, wr_count(inst) - w0); end
        checks++; if (reg_mism(inst) !== 0) begin errors++; $display("FAIL midrst_regs_after[%0d]: got %0d mismatching regs want 0", inst, reg_mism(inst)); end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ncs_p[i]  = 1'b1;
            sclk_p[i] = 1'b0;
            copi_p[i] = 1'b0;
            for (int k = 0; k < 16; k++) exp_r[i][k] = '0;
        end
        clks(4);
        test_reset;
        rst = 1'b0;
        clks(4);
        test_reset;
        for (int inst = 0; inst < 2; inst++) begin
            test_write(inst);
            test_read_back(inst);
            test_out_of_range(inst);
            test_abort(inst);
            test_drain(inst);
            test_reset_mid(inst);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
